// File: rtl/max7219_serial_driver_if.sv
// Request/status and serial-pin bundle between the display logic and the MAX7219 driver.
interface max7219_serial_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    update;
    logic [8*NUM_DIGITS-1:0] digits;
    logic [3:0]              intensity;
    logic                    busy;
    logic                    max_din;
    logic                    max_clk;
    logic                    max_load;

    modport master (
        output update, digits, intensity,
        input  busy, max_din, max_clk, max_load
    );

    modport slave (
        input  update, digits, intensity,
        output busy, max_din, max_clk, max_load
    );
endinterface

// File: rtl/max7219_serial_driver.sv
// MAX7219 driver: init sequence after reset, then full-display refreshes on request,
// each 16-bit register frame shifted MSB first over DIN/CLK/LOAD.
module max7219_serial_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    max7219_serial_driver_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {INIT, REFRESH, IDLE} state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [5:0]              half_cnt;   // 0..31 bit half-periods, 32..33 load/gap
    logic [3:0]              frame_idx;
    logic                    pending;
    logic [8*NUM_DIGITS-1:0] snap_digits;
    logic [3:0]              snap_int;
    logic [15:0]             word;
    logic                    half_end;
    logic                    frame_end;
    logic [5:0]              half_nxt;

    assign half_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign frame_end = half_end && (half_cnt == 6'd33);
    assign half_nxt  = half_cnt + 6'd1;

    always_comb begin
        word = 16'h0000;
        if (state == INIT) begin
            case (frame_idx)
                4'd0:    word = 16'h0C01;
                4'd1:    word = 16'h0900;
                4'd2:    word = {8'h0B, 8'(NUM_DIGITS - 1)};
                default: word = 16'h0F00;
            endcase
        end else if (frame_idx == 4'd0) begin
            word = {12'h0A0, snap_int};
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++)
                if (frame_idx == 4'(k + 1))
                    word = {4'h0, 4'(k + 1), snap_digits[8*k +: 8]};
        end
    end

    // Reset parks the counters on the last cycle of a phantom frame (index 0xF) so the
    // first edge after release rolls straight into INIT frame 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= INIT;
            div_cnt      <= DIV_W'(CLK_DIV - 1);
            half_cnt     <= 6'd33;
            frame_idx    <= 4'hF;
            pending      <= 1'b0;
            snap_digits  <= '0;
            snap_int     <= 4'h0;
            bus.busy     <= 1'b1;
            bus.max_load <= 1'b1;
            bus.max_clk  <= 1'b0;
            bus.max_din  <= 1'b0;
        end else begin
            if (bus.update && bus.busy)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.update) begin
                        state        <= REFRESH;
                        bus.busy     <= 1'b1;
                        frame_idx    <= 4'd0;
                        div_cnt      <= '0;
                        half_cnt     <= 6'd0;
                        snap_digits  <= bus.digits;
                        snap_int     <= bus.intensity;
                        bus.max_load <= 1'b0;
                    end
                end
                default: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!frame_end) begin
                            half_cnt <= half_nxt;
                            if (!half_nxt[5]) begin
                                bus.max_load <= 1'b0;
                                bus.max_clk  <= half_nxt[0];
                                bus.max_din  <= word[~half_nxt[4:1]];
                            end else begin
                                bus.max_load <= 1'b1;
                                bus.max_clk  <= 1'b0;
                                bus.max_din  <= 1'b0;
                            end
                        end else begin
                            // Every frame starts with a zero nibble, so bit 15 needs no lookup.
                            half_cnt     <= 6'd0;
                            frame_idx    <= frame_idx + 4'd1;
                            bus.max_load <= 1'b0;
                            bus.max_clk  <= 1'b0;
                            bus.max_din  <= 1'b0;
                            if (state == INIT && frame_idx == 4'd3) begin
                                state       <= REFRESH;
                                frame_idx   <= 4'd0;
                                snap_digits <= bus.digits;
                                snap_int    <= bus.intensity;
                            end else if (state == REFRESH && frame_idx == 4'(NUM_DIGITS)) begin
                                if (pending || bus.update) begin
                                    pending     <= 1'b0;
                                    frame_idx   <= 4'd0;
                                    snap_digits <= bus.digits;
                                    snap_int    <= bus.intensity;
                                end else begin
                                    state        <= IDLE;
                                    bus.busy     <= 1'b0;
                                    bus.max_load <= 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule
